// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
// Optional per-requester grant counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         gnt,
  input  logic                       fifo_full,
  output logic                       fifo_write,
  output logic [DATA_W-1:0]          fifo_din,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic [NUM_REQ*16-1:0]      stat_cnt
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [OW-1:0]      win_idx;
  logic               win_found;
  logic [NUM_REQ-1:0] gnt_raw;

  // Modulo add so non-power-of-2 requester counts wrap back to 0.
  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] base, input int unsigned ofs);
    int unsigned s;
    s = (32'(base) + ofs) % unsigned'(NUM_REQ);
    return OW'(s);
  endfunction

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[next_idx(rr_ptr_q, unsigned'(k))]) begin
        win_found = 1'b1;
        win_idx   = next_idx(rr_ptr_q, unsigned'(k));
      end
    end
  end

  always_comb begin
    gnt_raw  = '0;
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found && !fifo_full) begin
          gnt_raw[win_idx] = 1'b1;
          owner_d          = win_idx;
          if (MAX_BURST == 1) begin
            rr_ptr_d = next_idx(win_idx, 1);
          end else begin
            state_d = ST_BURST;
            beat_d  = BW'(1);
          end
        end
      end
      default: begin
        if (req[owner_q]) begin
          if (!fifo_full) begin
            gnt_raw[owner_q] = 1'b1;
            if (beat_q == BW'(MAX_BURST - 1)) begin
              state_d  = ST_IDLE;
              rr_ptr_d = next_idx(owner_q, 1);
              beat_d   = '0;
            end else begin
              beat_d = beat_q + BW'(1);
            end
          end
        end else begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_idx(owner_q, 1);
          beat_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

  assign gnt        = reset ? '0 : gnt_raw;
  assign fifo_write = |gnt;
  assign busy       = (state_q == ST_BURST);
  assign owner      = owner_q;

  always_comb begin
    fifo_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) fifo_din = req_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q[g] <= '0;
      end else if (gnt[g] && cnt_q[g] != 16'hFFFF) begin
        cnt_q[g] <= cnt_q[g] + 16'd1;
      end
    end
    assign stat_cnt[g*16 +: 16] = cnt_q[g];
  end
`else
  assign stat_cnt = '0;
`endif

endmodule
